sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Parametrised N-port front end for the QRAcc SRAM request interface. It arbitrates `numPorts` independent requesters, each with the SRAM request/response handshake, onto the single SRAM macro port. It keeps an in-order table of outstanding reads so each read response is routed back to the requester that issued it. It sits between the feature loader, activation/weight write paths and debug access on one side and the SRAM controller on the other, replacing a single fixed-width master.

## Interface
- `numPorts`, 4: number of requesters, 2..8.
- `numRows`, 128: SRAM rows; address width is `$clog2(numRows)`.
- `numCols`, 32: SRAM word width.
- `maxOutstanding`, 4: depth of the read-ID FIFO, power of two, ≥2.

- `clk` input 1: single clock, rising edge.
- `nrst` input 1: asynchronous, active-low reset.
- `m_rq_valid_i` input numPorts: per-port request valid.
- `m_rq_wr_i` input numPorts: per-port write(1)/read(0).
- `m_addr_i` input numPorts*AW: per-port address, port p at [p*AW +: AW].
- `m_wr_data_i` input numPorts*numCols: per-port write data.
- `m_rq_ready_o` output numPorts: per-port accept; one-hot or zero.
- `m_rd_valid_o` output numPorts: per-port read-data-valid pulse.
- `m_rd_data_o` output numPorts*numCols: per-port read data, holds last value.
- `s_rq_valid_o` output 1: request to SRAM.
- `s_rq_wr_o` output 1: write(1)/read(0).
- `s_addr_o` output AW: SRAM address.
- `s_wr_data_o` output numCols: SRAM write data.
- `s_rq_ready_i` input 1: SRAM accepts request.
- `s_rd_valid_i` input 1: SRAM read data valid; responses are returned in request order.
- `s_rd_data_i` input numCols: SRAM read data.
- `outstanding_o` output $clog2(maxOutstanding)+1: reads in flight.
- `err_o` output 1: sticky, set on a response received with no outstanding read.

## Operation
- Output register (OR) holds one request: valid, wr, addr, data, port id. `s_rq_*` are driven directly from the OR.
- OR can load when it is empty, or when `s_rq_valid_o && s_rq_ready_i` in the same cycle.
- Eligible port: `m_rq_valid_i[p]`, and either it is a write or `outstanding_o < maxOutstanding`.
- When the OR can load and at least one port is eligible, exactly one winner is chosen combinationally. Its `m_rq_ready_o[p]` is asserted that cycle and the OR loads at the clock edge.
- Arbitration is round-robin. The search starts at `rr_ptr`. On a grant, `rr_ptr` becomes winner+1 mod numPorts. Ineligible ports are skipped.
- Read-ID FIFO:
  - Push the OR port id when a read handshakes on the slave side (`s_rq_valid_o && s_rq_ready_i && !s_rq_wr_o`).
  - Pop on `s_rd_valid_i`.
  - Push and pop in the same cycle are both performed, so the count is unchanged.
- Eligibility uses the registered count, which is conservative: a same-cycle pop does not unblock a read grant.
- Read-ID FIFO counting covers reads already in the OR. `outstanding_o` = FIFO count + (OR holds a read). This prevents overflow.
- Response routing: on `s_rd_valid_i` with the FIFO non-empty, id = FIFO head. `m_rd_data_o[id]` ← `s_rd_data_i`, and `m_rd_valid_o[id]` pulses for one cycle.
- `s_rd_valid_i` with an empty FIFO: the data is dropped and `err_o` is set. `err_o` clears only on reset.
- Writes produce no response and use no FIFO entry.

## Timing
- Reset values: every output is 0, `rr_ptr`=0, the FIFO is empty and the OR is empty.
- Request latency: a master handshake in cycle t gives `s_rq_valid_o`=1 in cycle t+1.
- With the slave always ready, throughput is one request per cycle.
- `s_rq_*` are stable while `s_rq_valid_o && !s_rq_ready_i`.
- Read response latency: `s_rd_valid_i` in cycle t gives `m_rd_valid_o[id]` in cycle t+1.
- A master request may be withdrawn before it is granted. The arbiter does not require valid to be held.
- Reset mid-operation: the OR and FIFO are cleared. SRAM responses that arrive after reset for pre-reset reads set `err_o`.

## Configuration
- `SRAM_ARB_FIXED_PRIO_EN` defined: fixed priority, where the lowest-index eligible port always wins. `rr_ptr` is not implemented.
- Not defined: round-robin as specified above.

## Test plan
- Single port: port 0 writes addr 5 data 0xA5A5_0001, then reads addr 5. `s_rq_valid_o` appears one cycle after each grant. The SRAM returns 0xA5A5_0001, and `m_rd_valid_o`=0001 one cycle later with port 0 data 0xA5A5_0001.
- All four ports hold valid reads continuously with the slave always ready. Grants go 0,1,2,3,0,1… with one per cycle. With the macro defined, port 0 wins every grant.
- Slave holds `s_rq_ready_i`=0 for 5 cycles with `maxOutstanding`=4. Read grants stop once `outstanding_o`=4. A write from port 2 is still granted when the OR frees. The `s_rq_*` outputs stay stable while stalled.
- Interleaved reads port 3 addr 7, then port 1 addr 9; the SRAM returns 0x33, then 0x11. `m_rd_valid_o` pulses 1000 then 0010, with the matching data.
- A spurious `s_rd_valid_i` with no reads in flight leaves all `m_rd_valid_o` at 0 and sets `err_o`=1, which stays set until `nrst` is asserted.
- Assert `nrst` with 2 reads in flight. All outputs go to 0 and `outstanding_o`=0. The next normal read routes correctly.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// N-port SRAM request arbiter with in-order read-ID tracking for response routing.
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sram_port_arbiter #(
   parameter int numPorts       = 4,
   parameter int numRows        = 128,
   parameter int numCols        = 32,
   parameter int maxOutstanding = 4
) (
   input  logic                                   clk,
   input  logic                                   nrst,
   input  logic [numPorts-1:0]                    m_rq_valid_i,
   input  logic [numPorts-1:0]                    m_rq_wr_i,
   input  logic [numPorts*$clog2(numRows)-1:0]    m_addr_i,
   input  logic [numPorts*numCols-1:0]            m_wr_data_i,
   output logic [numPorts-1:0]                    m_rq_ready_o,
   output logic [numPorts-1:0]                    m_rd_valid_o,
   output logic [numPorts*numCols-1:0]            m_rd_data_o,
   output logic                                   s_rq_valid_o,
   output logic                                   s_rq_wr_o,
   output logic [$clog2(numRows)-1:0]             s_addr_o,
   output logic [numCols-1:0]                     s_wr_data_o,
   input  logic                                   s_rq_ready_i,
   input  logic                                   s_rd_valid_i,
   input  logic [numCols-1:0]                     s_rd_data_i,
   output logic [$clog2(maxOutstanding):0]        outstanding_o,
   output logic                                   err_o
);

   localparam int AW  = $clog2(numRows);
   localparam int PW  = $clog2(numPorts);
   localparam int FAW = $clog2(maxOutstanding);
   localparam int OW  = FAW + 1;
   localparam logic [OW-1:0] MAX_OUT = OW'(maxOutstanding);

   logic                               r_or_valid;
   logic                               r_or_wr;
   logic [AW-1:0]                      r_or_addr;
   logic [numCols-1:0]                 r_or_data;
   logic [PW-1:0]                      r_or_port;
   logic [PW-1:0]                      r_fifo [maxOutstanding];
   logic [FAW-1:0]                     r_wr_ptr;
   logic [FAW-1:0]                     r_rd_ptr;
   logic [OW-1:0]                      r_fifo_cnt;
   logic [numPorts-1:0]                r_rd_valid;
   logic [numPorts-1:0][numCols-1:0]   r_rd_data;
   logic                               r_err;
`ifndef SRAM_ARB_FIXED_PRIO_EN
   logic [PW-1:0]                      r_rr_ptr;
   int                                 w_idx;
`endif

   logic                w_s_hs;
   logic                w_load_ok;
   logic                w_push;
   logic                w_pop;
   logic                w_grant_any;
   logic [OW-1:0]       w_outstanding;
   logic [numPorts-1:0] w_elig;
   logic [numPorts-1:0] w_grant;
   logic [PW-1:0]       w_win;
   logic [PW-1:0]       w_head;
   logic [AW-1:0]       w_sel_addr;
   logic [numCols-1:0]  w_sel_data;
   logic                w_sel_wr;

   assign w_s_hs        = r_or_valid & s_rq_ready_i;
   assign w_load_ok     = ~r_or_valid | s_rq_ready_i;
   // A read sitting in the output register already counts against the limit.
   assign w_outstanding = r_fifo_cnt + OW'(r_or_valid & ~r_or_wr);
   assign w_elig        = m_rq_valid_i & (m_rq_wr_i | {numPorts{w_outstanding < MAX_OUT}});
   assign w_push        = w_s_hs & ~r_or_wr;
   assign w_pop         = s_rd_valid_i & (r_fifo_cnt != '0);
   assign w_head        = r_fifo[r_rd_ptr];

   always_comb begin
      w_grant_any = 1'b0;
      w_win       = '0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < numPorts; i++) begin
         if (w_load_ok && !w_grant_any && w_elig[i]) begin
            w_grant_any = 1'b1;
            w_win       = PW'(i);
         end
      end
`else
      w_idx = 0;
      for (int i = 0; i < numPorts; i++) begin
         w_idx = int'(r_rr_ptr) + i;
         if (w_idx >= numPorts) w_idx = w_idx - numPorts;
         if (w_load_ok && !w_grant_any && w_elig[w_idx]) begin
            w_grant_any = 1'b1;
            w_win       = PW'(w_idx);
         end
      end
`endif
   end

   always_comb begin
      w_grant    = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      w_sel_wr   = 1'b0;
      for (int p = 0; p < numPorts; p++) begin
         if (w_win == PW'(p)) begin
            w_sel_addr = m_addr_i[p*AW +: AW];
            w_sel_data = m_wr_data_i[p*numCols +: numCols];
            w_sel_wr   = m_rq_wr_i[p];
            w_grant[p] = w_grant_any;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_or_valid <= 1'b0;
         r_or_wr    <= 1'b0;
         r_or_addr  <= '0;
         r_or_data  <= '0;
         r_or_port  <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         r_rr_ptr   <= '0;
`endif
      end else if (w_grant_any) begin
         r_or_valid <= 1'b1;
         r_or_wr    <= w_sel_wr;
         r_or_addr  <= w_sel_addr;
         r_or_data  <= w_sel_data;
         r_or_port  <= w_win;
`ifndef SRAM_ARB_FIXED_PRIO_EN
         r_rr_ptr   <= (w_win == PW'(numPorts - 1)) ? '0 : w_win + PW'(1);
`endif
      end else if (w_s_hs) begin
         r_or_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int k = 0; k < maxOutstanding; k++) r_fifo[k] <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= r_or_port;
            r_wr_ptr         <= r_wr_ptr + FAW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + FAW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + OW'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - OW'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_rd_valid <= '0;
         r_rd_data  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_rd_valid <= '0;
         if (w_pop) begin
            r_rd_valid[w_head] <= 1'b1;
            r_rd_data[w_head]  <= s_rd_data_i;
         end else if (s_rd_valid_i) begin
            r_err <= 1'b1;
         end
      end
   end

   assign m_rq_ready_o  = w_grant;
   assign m_rd_valid_o  = r_rd_valid;
   assign m_rd_data_o   = r_rd_data;
   assign s_rq_valid_o  = r_or_valid;
   assign s_rq_wr_o     = r_or_wr;
   assign s_addr_o      = r_or_addr;
   assign s_wr_data_o   = r_or_data;
   assign outstanding_o = w_outstanding;
   assign err_o         = r_err;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_sram_port_arbiter;

   localparam int NP = 4;
   localparam int NR = 128;
   localparam int NC = 32;
   localparam int MO = 4;
   localparam int AW = 7;

   logic              clk = 1'b0;
   logic              nrst;
   logic [NP-1:0]     m_rq_valid_i;
   logic [NP-1:0]     m_rq_wr_i;
   logic [NP*AW-1:0]  m_addr_i;
   logic [NP*NC-1:0]  m_wr_data_i;
   logic [NP-1:0]     m_rq_ready_o;
   logic [NP-1:0]     m_rd_valid_o;
   logic [NP*NC-1:0]  m_rd_data_o;
   logic              s_rq_valid_o;
   logic              s_rq_wr_o;
   logic [AW-1:0]     s_addr_o;
   logic [NC-1:0]     s_wr_data_o;
   logic              s_rq_ready_i;
   logic              s_rd_valid_i;
   logic [NC-1:0]     s_rd_data_i;
   logic [2:0]        outstanding_o;
   logic              err_o;

   sram_port_arbiter #(.numPorts(NP), .numRows(NR), .numCols(NC), .maxOutstanding(MO)) dut (
      .clk(clk), .nrst(nrst),
      .m_rq_valid_i(m_rq_valid_i), .m_rq_wr_i(m_rq_wr_i), .m_addr_i(m_addr_i),
      .m_wr_data_i(m_wr_data_i), .m_rq_ready_o(m_rq_ready_o), .m_rd_valid_o(m_rd_valid_o),
      .m_rd_data_o(m_rd_data_o), .s_rq_valid_o(s_rq_valid_o), .s_rq_wr_o(s_rq_wr_o),
      .s_addr_o(s_addr_o), .s_wr_data_o(s_wr_data_o), .s_rq_ready_i(s_rq_ready_i),
      .s_rd_valid_i(s_rd_valid_i), .s_rd_data_i(s_rd_data_i),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          rr;
   bit          or_v, or_wr;
   logic [AW-1:0] or_addr;
   logic [NC-1:0] or_data;
   int          or_port;
   int          rdq[$];
   logic [NP-1:0] e_rdv;
   logic [NC-1:0] e_rdd [NP];
   bit          e_err;
   logic [NP-1:0] last_ready;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rr = 0; or_v = 0; or_wr = 0; or_addr = '0; or_data = '0; or_port = 0;
      rdq.delete();
      e_rdv = '0; e_err = 0;
      for (int p = 0; p < NP; p++) e_rdd[p] = '0;
   endtask

   task automatic idle();
      m_rq_valid_i = '0; m_rq_wr_i = '0; m_addr_i = '0; m_wr_data_i = '0;
      s_rq_ready_i = 1'b1; s_rd_valid_i = 1'b0; s_rd_data_i = '0;
   endtask

   task automatic set_req(input int p, input bit wr, input int addr, input logic [NC-1:0] d);
      logic [AW-1:0] a;
      a = AW'(addr);
      m_rq_valid_i[p] = 1'b1;
      m_rq_wr_i[p] = wr;
      m_addr_i[p*AW +: AW] = a;
      m_wr_data_i[p*NC +: NC] = d;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, 128'(m_rq_ready_o), 0);
      chk({tag, "_rdv"}, 128'(m_rd_valid_o), 0);
      chk({tag, "_rdd"}, m_rd_data_o, 0);
      chk({tag, "_sv"}, 128'(s_rq_valid_o), 0);
      chk({tag, "_swr"}, 128'(s_rq_wr_o), 0);
      chk({tag, "_saddr"}, 128'(s_addr_o), 0);
      chk({tag, "_sdata"}, 128'(s_wr_data_o), 0);
      chk({tag, "_outst"}, 128'(outstanding_o), 0);
      chk({tag, "_err"}, 128'(err_o), 0);
   endtask

   // Inputs are already applied just after a falling edge; checks this cycle, advances the model.
   task automatic cycle();
      int out, win, p, id;
      logic [NP-1:0] exp_ready, rdv_n;
      logic [NP*NC-1:0] exp_flat;
      bit hs;
      #1;
      out = rdq.size() + ((or_v && !or_wr) ? 1 : 0);
      win = -1;
      if (!or_v || s_rq_ready_i) begin
         for (int k = 0; k < NP; k++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            p = k;
`else
            p = (rr + k) % NP;
`endif
            if (win < 0 && m_rq_valid_i[p] && (m_rq_wr_i[p] || out < MO)) win = p;
         end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      for (int q = 0; q < NP; q++) exp_flat[q*NC +: NC] = e_rdd[q];
      last_ready = m_rq_ready_o;
      chk("grant", 128'(m_rq_ready_o), 128'(exp_ready));
      chk("s_valid", 128'(s_rq_valid_o), 128'(or_v));
      if (or_v) begin
         chk("s_wr", 128'(s_rq_wr_o), 128'(or_wr));
         chk("s_addr", 128'(s_addr_o), 128'(or_addr));
         chk("s_data", 128'(s_wr_data_o), 128'(or_data));
      end
      chk("outstanding", 128'(outstanding_o), 128'(out));
      chk("rd_valid", 128'(m_rd_valid_o), 128'(e_rdv));
      chk("rd_data", m_rd_data_o, exp_flat);
      chk("err", 128'(err_o), 128'(e_err));
      hs = or_v && s_rq_ready_i;
      rdv_n = '0;
      if (s_rd_valid_i) begin
         if (rdq.size() > 0) begin
            id = rdq.pop_front();
            rdv_n[id] = 1'b1;
            e_rdd[id] = s_rd_data_i;
         end else begin
            e_err = 1;
         end
      end
      if (hs && !or_wr) rdq.push_back(or_port);
      if (win >= 0) begin
         or_v = 1; or_wr = m_rq_wr_i[win]; or_port = win;
         or_addr = m_addr_i[win*AW +: AW];
         or_data = m_wr_data_i[win*NC +: NC];
         rr = (win + 1) % NP;
      end else if (hs) begin
         or_v = 0;
      end
      e_rdv = rdv_n;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && (rdq.size() > 0 || or_v); k++) begin
         idle();
         s_rd_valid_i = (rdq.size() > 0);
         s_rd_data_i = $urandom;
         cycle();
      end
      chk("drained", 128'(outstanding_o), 0);
   endtask

   initial begin
      logic [AW-1:0] saved_addr;
      model_reset();
      idle();
      nrst = 1'b0;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      nrst = 1'b1;

      // all ports reading continuously, slave always ready
      for (int k = 0; k < 8; k++) begin
         idle();
         for (int p = 0; p < NP; p++) set_req(p, 0, $urandom_range(0, NR - 1), $urandom);
         s_rd_valid_i = (rdq.size() > 0);
         s_rd_data_i = $urandom;
         cycle();
`ifdef SRAM_ARB_FIXED_PRIO_EN
         chk("rr_seq", 128'(last_ready), 128'(4'b0001));
`else
         chk("rr_seq", 128'(last_ready), 128'(4'b0001 << (k % 4)));
`endif
      end
      drain();

      // single port write then read of the same address
      idle(); set_req(0, 1, 5, 32'hA5A5_0001); cycle();
      chk("t1_wgrant", 128'(last_ready), 1);
      chk("t1_wvalid", 128'(s_rq_valid_o), 1);
      chk("t1_waddr", 128'(s_addr_o), 5);
      chk("t1_wdata", 128'(s_wr_data_o), 128'(32'hA5A5_0001));
      idle(); set_req(0, 0, 5, 0); cycle();
      chk("t1_rgrant", 128'(last_ready), 1);
      chk("t1_rwr", 128'(s_rq_wr_o), 0);
      idle(); cycle();
      idle(); s_rd_valid_i = 1'b1; s_rd_data_i = 32'hA5A5_0001; cycle();
      chk("t1_rdv", 128'(m_rd_valid_o), 1);
      chk("t1_rdd", 128'(m_rd_data_o[31:0]), 128'(32'hA5A5_0001));
      drain();

      // interleaved reads from ports 3 and 1
      idle(); set_req(3, 0, 7, 0); cycle();
      chk("il_g3", 128'(last_ready), 128'(4'b1000));
      idle(); set_req(1, 0, 9, 0); cycle();
      chk("il_g1", 128'(last_ready), 128'(4'b0010));
      idle(); cycle();
      idle(); s_rd_valid_i = 1'b1; s_rd_data_i = 32'h33; cycle();
      chk("il_rdv3", 128'(m_rd_valid_o), 128'(4'b1000));
      chk("il_rdd3", 128'(m_rd_data_o[127:96]), 128'(32'h33));
      idle(); s_rd_valid_i = 1'b1; s_rd_data_i = 32'h11; cycle();
      chk("il_rdv1", 128'(m_rd_valid_o), 128'(4'b0010));
      chk("il_rdd1", 128'(m_rd_data_o[63:32]), 128'(32'h11));
      drain();

      // fill to the read limit, then stall the slave
      for (int k = 0; k < 4; k++) begin
         idle();
         set_req(0, 0, 10, 0); set_req(1, 0, 11, 0); set_req(3, 0, 13, 0);
         cycle();
      end
      chk("st_full", 128'(outstanding_o), 4);
      saved_addr = s_addr_o;
      for (int k = 0; k < 5; k++) begin
         idle();
         set_req(0, 0, 10, 0); set_req(1, 0, 11, 0); set_req(3, 0, 13, 0);
         set_req(2, 1, 22, 32'hCAFE_0002);
         s_rq_ready_i = 1'b0;
         cycle();
         chk("st_nogrant", 128'(last_ready), 0);
         chk("st_hold_v", 128'(s_rq_valid_o), 1);
         chk("st_hold_a", 128'(s_addr_o), 128'(saved_addr));
      end
      idle();
      set_req(0, 0, 10, 0); set_req(1, 0, 11, 0); set_req(3, 0, 13, 0);
      set_req(2, 1, 22, 32'hCAFE_0002);
      cycle();
      chk("st_wgrant", 128'(last_ready), 128'(4'b0100));
      chk("st_wr", 128'(s_rq_wr_o), 1);
      chk("st_out4", 128'(outstanding_o), 4);
      drain();

      // response with nothing in flight
      idle(); s_rd_valid_i = 1'b1; s_rd_data_i = 32'hDEAD; cycle();
      chk("sp_rdv", 128'(m_rd_valid_o), 0);
      chk("sp_err", 128'(err_o), 1);
      for (int k = 0; k < 3; k++) begin idle(); cycle(); end
      chk("sp_sticky", 128'(err_o), 1);

      // random traffic
      for (int k = 0; k < 400; k++) begin
         m_rq_valid_i = NP'($urandom);
         m_rq_wr_i = NP'($urandom);
         for (int p = 0; p < NP; p++) begin
            m_addr_i[p*AW +: AW] = AW'($urandom);
            m_wr_data_i[p*NC +: NC] = $urandom;
         end
         s_rq_ready_i = ($urandom_range(0, 3) != 0);
         s_rd_valid_i = (rdq.size() > 0) && ($urandom_range(0, 1) == 1);
         s_rd_data_i = $urandom;
         cycle();
      end
      drain();

      // reset with two reads in flight
      idle(); set_req(0, 0, 1, 0); cycle();
      idle(); set_req(2, 0, 2, 0); cycle();
      idle(); cycle();
      chk("mr_two", 128'(outstanding_o), 2);
      idle();
      nrst = 1'b0;
      #1;
      check_all_zero("mid_reset");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      idle(); set_req(2, 0, 3, 0); cycle();
      chk("mr_grant", 128'(last_ready), 128'(4'b0100));
      idle(); cycle();
      idle(); s_rd_valid_i = 1'b1; s_rd_data_i = 32'hBEEF; cycle();
      chk("mr_rdv", 128'(m_rd_valid_o), 128'(4'b0100));
      chk("mr_rdd", 128'(m_rd_data_o[95:64]), 128'(32'hBEEF));
      chk("mr_noerr", 128'(err_o), 0);
      idle(); s_rd_valid_i = 1'b1; s_rd_data_i = 32'h5; cycle();
      chk("mr_stale_err", 128'(err_o), 1);
      idle(); cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
